// File: rtl/mem_responder_pkg.sv
// Shared encodings for the memory responder: access sizes, FSM states and latency limit.
package mem_responder_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    localparam int MAX_LATENCY = 15;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    // Clears the low address bits a size must keep zero; the illegal size aligns as a word.
    function automatic logic [1:0] force_align(input logic [1:0] size, input logic [1:0] lo);
        logic [1:0] r;
        case (size)
            SIZE_BYTE: r = lo;
            SIZE_HALF: r = {lo[1], 1'b0};
            default:   r = 2'b00;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mem_lane_sel.sv
// Byte-lane steering for one little-endian 32-bit word: write mask, replicated
// store data, right-aligned zero-extended load data and misalignment flag.
module mem_lane_sel
    import mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [3:0]  be,
    output logic [31:0] wword,
    output logic [31:0] rdata,
    output logic        misalign
);

    // Lane decode per access size; the illegal size behaves as a word.
    always_comb begin
        be       = 4'b0000;
        wword    = 32'h0000_0000;
        rdata    = 32'h0000_0000;
        misalign = 1'b0;
        case (size)
            SIZE_BYTE: begin
                be       = 4'b0001 << addr_lo;
                wword    = {4{wdata[7:0]}};
                rdata    = {24'h00_0000, rword[{addr_lo, 3'b000} +: 8]};
                misalign = 1'b0;
            end
            SIZE_HALF: begin
                be       = addr_lo[1] ? 4'b1100 : 4'b0011;
                wword    = {2{wdata[15:0]}};
                rdata    = {16'h0000, rword[{addr_lo[1], 4'b0000} +: 16]};
                misalign = addr_lo[0];
            end
            default: begin
                be       = 4'b1111;
                wword    = wdata;
                rdata    = rword;
                misalign = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder with programmable latency and byte-lane RAM.
// Define MEM_RESPONDER_ALIGN_CHK_EN for alignment/range/size fault reporting.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = $clog2(MAX_LATENCY + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    state_e         state_r;
    logic [CW-1:0]  cnt_r;
    logic           write_r;
    logic [1:0]     size_r;
    logic [31:0]    addr_r;
    logic [31:0]    wdata_r;
    logic [31:0]    mem_r [DEPTH_WORDS];

    logic [1:0]     lo_s;
    logic [AW-1:0]  widx_s;
    logic           err_s;
    logic           commit_s;
    logic [3:0]     be_s;
    logic [31:0]    wword_s;
    logic [31:0]    ldata_s;
    logic [31:0]    rword_s;
    logic [31:0]    merged_s;
    logic           misalign_s;

    assign widx_s   = addr_r[AW+1:2];
    assign rword_s  = mem_r[widx_s];
    assign commit_s = (state_r == ST_WAIT) && (cnt_r == {CW{1'b0}});

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    assign lo_s = addr_r[1:0];

    // Fault decision for the captured request.
    always_comb begin
        if (misalign_s || (addr_r[31:AW+2] != {(30-AW){1'b0}}) || (size_r == 2'b11)) begin
            err_s = 1'b1;
        end else begin
            err_s = 1'b0;
        end
    end
`else
    // Without checking, upper address bits wrap and the lane flag is meaningless.
    logic unused_s;
    assign unused_s = ^{addr_r[31:AW+2], misalign_s};
    assign lo_s     = force_align(size_r, addr_r[1:0]);
    assign err_s    = 1'b0;
`endif

    mem_lane_sel u_lane_sel (
        .size     (size_r),
        .addr_lo  (lo_s),
        .wdata    (wdata_r),
        .rword    (rword_s),
        .be       (be_s),
        .wword    (wword_s),
        .rdata    (ldata_s),
        .misalign (misalign_s)
    );

    // Merge enabled store lanes into the current word.
    always_comb begin
        merged_s = rword_s;
        for (int i = 0; i < 4; i++) begin
            if (be_s[i]) begin
                merged_s[8*i +: 8] = wword_s[8*i +: 8];
            end else begin
                merged_s[8*i +: 8] = rword_s[8*i +: 8];
            end
        end
    end

    // Store at the commit edge; RAM is deliberately not cleared by reset.
    always_ff @(posedge clock) begin
        if (commit_s && write_r && !err_s) begin
            mem_r[widx_s] <= merged_s;
        end
    end

    // Request/response sequencer. Every latency, including 1, passes through WAIT so
    // resp_valid always rises LATENCY edges after acceptance.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_IDLE;
            cnt_r      <= {CW{1'b0}};
            write_r    <= 1'b0;
            size_r     <= SIZE_WORD;
            addr_r     <= 32'h0000_0000;
            wdata_r    <= 32'h0000_0000;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= 32'h0000_0000;
            resp_err   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        write_r   <= req_write;
                        size_r    <= req_size;
                        addr_r    <= req_addr;
                        wdata_r   <= req_wdata;
                        cnt_r     <= CNT_INIT;
                        req_ready <= 1'b0;
                        state_r   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CW{1'b0}}) begin
                        state_r    <= ST_RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= err_s;
                        resp_rdata <= (write_r || err_s) ? 32'h0000_0000 : ldata_s;
                    end else begin
                        cnt_r <= cnt_r - CW'(1);
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_r    <= ST_IDLE;
                        resp_valid <= 1'b0;
                        resp_rdata <= 32'h0000_0000;
                        resp_err   <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    cnt_r      <= {CW{1'b0}};
                    req_ready  <= 1'b1;
                    resp_valid <= 1'b0;
                    resp_rdata <= 32'h0000_0000;
                    resp_err   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: directed vector table, corner sequences,
// then randomized traffic against a byte-array reference memory.
module tb_mem_responder;

    localparam int DEPTH = 256;
    localparam int LAT   = 2;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] ref_mem [DEPTH*4];

    mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
        .clock      (clock),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: a flat byte array addressed by the rules of the access, not by lanes.
    function automatic void model(input logic wr, input logic [1:0] sz, input logic [31:0] a,
                                  input logic [31:0] wd, output logic err, output logic [31:0] rd);
        int unsigned nb;
        int unsigned ea;
        nb = (sz == 2'b10) ? 1 : (sz == 2'b01) ? 2 : 4;
        if (CHK) begin
            err = ((a % nb) != 0) || (a >= DEPTH*4) || (sz == 2'b11);
            ea  = a;
        end else begin
            err = 1'b0;
            ea  = (a - (a % nb)) % (DEPTH*4);
        end
        rd = 32'h0;
        if (!err) begin
            for (int k = 0; k < int'(nb); k++) begin
                if (wr) ref_mem[ea+k] = wd[8*k +: 8];
                else    rd[8*k +: 8] = ref_mem[ea+k];
            end
        end
    endfunction

    // One complete transaction; hold cycles of backpressure with an ignored request.
    task automatic do_txn(input string name, input logic wr, input logic [1:0] sz,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp_rd, input logic exp_er, input int hold);
        int n;
        n = 0;
        while (!req_ready && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check({name, " ready_before"}, {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = a; req_wdata = wd;
        @(posedge clock); #1;
        req_valid = 1'b0;
        n = 0;
        while (!resp_valid && n < 40) begin
            @(posedge clock); #1; n++;
        end
        check({name, " latency"}, n, LAT);
        check({name, " rdata"}, resp_rdata, exp_rd);
        check({name, " err"}, {31'h0, resp_err}, {31'h0, exp_er});
        for (int h = 0; h < hold; h++) begin
            req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
            req_addr = a; req_wdata = 32'hFFFF_FFFF;
            @(posedge clock); #1;
            check({name, " hold_valid"}, {31'h0, resp_valid}, 32'h1);
            check({name, " hold_rdata"}, resp_rdata, exp_rd);
            check({name, " hold_ready"}, {31'h0, req_ready}, 32'h0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clock); #1;
        resp_ready = 1'b0;
        check({name, " post_valid"}, {31'h0, resp_valid}, 32'h0);
        check({name, " post_rdata"}, resp_rdata, 32'h0);
        check({name, " post_ready"}, {31'h0, req_ready}, 32'h1);
    endtask

    typedef struct {
        string       name;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [31:0] exp_rd;
        logic        exp_er;
    } vec_t;

    initial begin
        vec_t vecs[$];
        logic        e;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] wd;
        logic [1:0]  sz;
        logic        wr;

        vecs.push_back('{"w10",     1'b1, 2'b00, 32'h010, 32'hDEAD_BEEF, 32'h0, 1'b0});
        vecs.push_back('{"r10",     1'b0, 2'b00, 32'h010, 32'h0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{"wb12",    1'b1, 2'b10, 32'h012, 32'h0000_0055, 32'h0, 1'b0});
        vecs.push_back('{"r10b",    1'b0, 2'b00, 32'h010, 32'h0, 32'hDE55_BEEF, 1'b0});
        vecs.push_back('{"rh12",    1'b0, 2'b01, 32'h012, 32'h0, 32'h0000_DE55, 1'b0});
        vecs.push_back('{"rb13",    1'b0, 2'b10, 32'h013, 32'h0, 32'h0000_00DE, 1'b0});
        vecs.push_back('{"wh10",    1'b1, 2'b01, 32'h010, 32'h1234_A1B2, 32'h0, 1'b0});
        vecs.push_back('{"r10c",    1'b0, 2'b00, 32'h010, 32'h0, 32'hDE55_A1B2, 1'b0});
        vecs.push_back('{"w000",    1'b1, 2'b00, 32'h000, 32'h1122_3344, 32'h0, 1'b0});
        vecs.push_back('{"w004",    1'b1, 2'b00, 32'h004, 32'h0BAD_C0DE, 32'h0, 1'b0});
        vecs.push_back('{"w3fc",    1'b1, 2'b00, 32'h3FC, 32'hA0B1_C2D3, 32'h0, 1'b0});
        vecs.push_back('{"r3fc",    1'b0, 2'b00, 32'h3FC, 32'h0, 32'hA0B1_C2D3, 1'b0});
        vecs.push_back('{"rh11",    1'b0, 2'b01, 32'h011, 32'h0, CHK ? 32'h0 : 32'h0000_A1B2, CHK});
        vecs.push_back('{"rh13",    1'b0, 2'b01, 32'h013, 32'h0, CHK ? 32'h0 : 32'h0000_DE55, CHK});
        vecs.push_back('{"w402",    1'b1, 2'b00, 32'h402, 32'hCAFE_F00D, 32'h0, CHK});
        vecs.push_back('{"r000",    1'b0, 2'b00, 32'h000, 32'h0, CHK ? 32'h1122_3344 : 32'hCAFE_F00D, 1'b0});
        vecs.push_back('{"r404",    1'b0, 2'b00, 32'h404, 32'h0, CHK ? 32'h0 : 32'h0BAD_C0DE, CHK});
        vecs.push_back('{"rsz11",   1'b0, 2'b11, 32'h010, 32'h0, CHK ? 32'h0 : 32'hDE55_A1B2, CHK});

        reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
        req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst req_ready", {31'h0, req_ready}, 32'h1);
        check("rst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst resp_rdata", resp_rdata, 32'h0);
        check("rst resp_err", {31'h0, resp_err}, 32'h0);
        reset = 1'b1;
        resp_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        resp_ready = 1'b0;
        check("idle resp_ready no effect", {31'h0, resp_valid}, 32'h0);

        foreach (vecs[i]) begin
            do_txn(vecs[i].name, vecs[i].wr, vecs[i].sz, vecs[i].addr, vecs[i].wd,
                   vecs[i].exp_rd, vecs[i].exp_er, 0);
        end

        // Backpressure: held response stays stable and an in-RESP store is ignored.
        do_txn("bp", 1'b0, 2'b00, 32'h010, 32'h0, 32'hDE55_A1B2, 1'b0, 5);
        do_txn("bp_after", 1'b0, 2'b00, 32'h010, 32'h0, 32'hDE55_A1B2, 1'b0, 0);

        // Reset before the commit edge discards an in-flight store.
        do_txn("w20", 1'b1, 2'b00, 32'h020, 32'hA5A5_A5A5, 32'h0, 1'b0, 0);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00;
        req_addr = 32'h020; req_wdata = 32'h1234_5678;
        @(posedge clock); #1;
        req_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("midrst req_ready", {31'h0, req_ready}, 32'h1);
        check("midrst resp_valid", {31'h0, resp_valid}, 32'h0);
        check("midrst resp_rdata", resp_rdata, 32'h0);
        check("midrst resp_err", {31'h0, resp_err}, 32'h0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        do_txn("r20", 1'b0, 2'b00, 32'h020, 32'h0, 32'hA5A5_A5A5, 1'b0, 0);

        // Fill the whole RAM so every random read has a known value.
        for (int w = 0; w < DEPTH; w++) begin
            wd = $urandom;
            model(1'b1, 2'b00, w * 4, wd, e, r);
            do_txn("fill", 1'b1, 2'b00, w * 4, wd, r, e, 0);
        end

        for (int t = 0; t < 300; t++) begin
            wr = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            a  = $urandom_range(0, DEPTH * 8 - 1);
            if ($urandom_range(0, 3) != 0) begin
                a = (sz == 2'b10) ? a : (sz == 2'b01) ? (a & 32'hFFFF_FFFE) : (a & 32'hFFFF_FFFC);
            end
            wd = $urandom;
            model(wr, sz, a, wd, e, r);
            do_txn("rand", wr, sz, a, wd, r, e, (t % 37 == 0) ? 2 : 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
